// File: rtl/final_soc_key_capture.sv
// ---------------------------------------------------------------------------
// final_soc_key_capture : debounced key inputs with Avalon-MM press capture/IRQ
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module final_soc_key_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb;
  logic [15:0]      cnt [WIDTH];
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;

  logic [WIDTH-1:0] mismatch;
  logic [WIDTH-1:0] settle;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] clear_bits;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    mismatch = '0;
    settle   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mismatch[i] = sync2[i] ^ deb[i];
      settle[i]   = mismatch[i] && (cnt[i] == CNT_MAX);
    end
  end

  // A settling bit whose old level is 1 is about to fall: that is a press.
  assign press      = settle & deb;
  assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1       <= '1;
      sync2       <= '1;
      deb         <= '1;
      irqmask     <= '0;
      edgecapture <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (settle[i]) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else if (mismatch[i]) begin
          cnt[i] <= cnt[i] + 16'd1;
        end else begin
          cnt[i] <= '0;
        end
      end
      if (wr_en && address == 2'd2) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      // A press on the clearing edge survives the clear.
      edgecapture <= (edgecapture & ~clear_bits) | press;
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata[WIDTH-1:0] = deb;
        2'd2:    readdata[WIDTH-1:0] = irqmask;
        2'd3:    readdata[WIDTH-1:0] = edgecapture;
        default: readdata = '0;
      endcase
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

`default_nettype wire

// File: tb/tb_final_soc_key_capture.sv
// ---------------------------------------------------------------------------
// tb_final_soc_key_capture : directed self-checking bench, WIDTH=4, DEBOUNCE_CYCLES=4
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_final_soc_key_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int asserts_done = 0;
  int fails        = 0;

  final_soc_key_capture #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts_done++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  // Write lands on the next rising edge; returns 1 time unit after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    tick(3);
    reset_n = 1'b1;

    // Reset state
    rd(2'd0, 32'hF, "reset_deb");
    rd(2'd2, 32'h0, "reset_mask");
    rd(2'd3, 32'h0, "reset_edge");
    check("reset_irq", {31'd0, irq}, 32'd0);
    address = 2'd0; chipselect = 1'b0; #1;
    check("cs0_reads_zero", readdata, 32'h0);

    // Glitch of 3 cycles on key 1 is rejected
    in_port = 4'b1101;
    tick(3);
    in_port = 4'hF;
    tick(8);
    rd(2'd0, 32'hF, "glitch_deb");
    rd(2'd3, 32'h0, "glitch_edge");

    // Held press on key 1: deb changes on the 6th edge
    in_port = 4'b1101;
    tick(5);
    rd(2'd0, 32'hF, "press1_edge5");
    tick(1);
    rd(2'd0, 32'hD, "press1_edge6");
    rd(2'd3, 32'h2, "press1_capture");
    check("press1_irq_masked", {31'd0, irq}, 32'd0);

    // Mask enables irq on the cycle after the write; W1C clears it
    wr(2'd2, 32'h2);
    check("mask_irq_on", {31'd0, irq}, 32'd1);
    rd(2'd2, 32'h2, "mask_readback");
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h0, "w1c_edge");
    check("w1c_irq_off", {31'd0, irq}, 32'd0);

    // Release key 1: no capture on 0->1
    in_port = 4'hF;
    tick(8);
    rd(2'd0, 32'hF, "release1_deb");
    rd(2'd3, 32'h0, "release1_no_edge");

    // Clear and new press on key 2 on the same edge: set wins
    in_port = 4'b1011;
    tick(5);
    wr(2'd3, 32'h4);
    rd(2'd0, 32'hB, "press2_deb");
    rd(2'd3, 32'h4, "set_wins");
    check("press2_irq_masked", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'h4);
    check("press2_irq_on", {31'd0, irq}, 32'd1);
    in_port = 4'hF;
    tick(8);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h0, "press2_cleared");
    rd(2'd0, 32'hF, "release2_deb");

    // Reset during a press with counter at 2: debounce abandoned
    in_port = 4'b1110;
    tick(4);
    reset_n = 1'b0;
    in_port = 4'hF;
    tick(1);
    reset_n = 1'b1;
    tick(8);
    rd(2'd0, 32'hF, "midreset_deb");
    rd(2'd3, 32'h0, "midreset_edge");
    rd(2'd2, 32'h0, "midreset_mask");
    check("midreset_irq", {31'd0, irq}, 32'd0);

    // Writes to addr 0/1 are ignored
    wr(2'd0, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd0, 32'hF, "ro_addr0");
    rd(2'd1, 32'h0, "addr1_zero");

    // Key 3 held through reset is reported after release
    in_port = 4'b0111;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(5);
    rd(2'd0, 32'hF, "boot_edge5");
    tick(1);
    rd(2'd0, 32'h7, "boot_deb");
    rd(2'd3, 32'h8, "boot_capture");
    check("boot_irq_masked", {31'd0, irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_done, fails);
    $finish;
  end

endmodule

`default_nettype wire
